rf_port_arbiter: RTL and testbench

Shares the single write port and the two read ports of `reg_file` (12-entry rs space, 8-entry rt space, 4-entry rd space, 8-bit data) between two requesters, e.g. the core pipeline (requester 0) and the loader/debug unit (requester 1). Each requester issues read-pair or write transactions over a valid/ready handshake. The arbiter grants one transaction per cycle in round-robin order, registers it into a single issue stage that drives `reg_file`, and returns read data through a per-requester response slot with its own valid/ready handshake.

---
 rtl/rf_pkg.sv | 29 ++
 rtl/rr_arb2.sv | 30 +++
 rtl/rf_port_arbiter.sv | 125 ++++++++++++
 tb/tb_rf_port_arbiter.sv | 321 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/rf_pkg.sv
// Shared types and constants for the reg_file port arbiter.
package rf_pkg;

    localparam int REG_WIDTH = 8;
    localparam int RS_AW     = 4;
    localparam int RT_AW     = 3;
    localparam int RD_AW     = 2;
    localparam int RS_DEPTH  = 12;

    typedef struct packed {
        logic                 write;
        logic [RS_AW-1:0]     rs;
        logic [RT_AW-1:0]     rt;
        logic [RD_AW-1:0]     rd;
        logic [REG_WIDTH-1:0] wdata;
    } rf_req_t;

    typedef struct packed {
        logic [REG_WIDTH-1:0] rs_data;
        logic [REG_WIDTH-1:0] rt_data;
        logic                 err;
    } rf_rsp_t;

    // rs space is not a power of two, so the top addresses are illegal.
    function automatic logic rs_out_of_range(input logic [RS_AW-1:0] addr);
        return addr >= RS_AW'(RS_DEPTH);
    endfunction

endpackage

// File: rtl/rr_arb2.sv
// Two-way round-robin arbiter; the requester not granted most recently wins.
module rr_arb2 (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [1:0] req,
    input  logic       update,
    output logic [1:0] gnt
);

    logic rr_last;

    always_comb begin
        gnt = 2'b00;
        if (req[0] && (!req[1] || rr_last)) begin
            gnt[0] = 1'b1;
        end else if (req[1]) begin
            gnt[1] = 1'b1;
        end
    end

    // Starting at 1 gives requester 0 first priority out of reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rr_last <= 1'b1;
        end else if (update && (gnt != 2'b00)) begin
            rr_last <= gnt[1];
        end
    end

endmodule

// File: rtl/rf_port_arbiter.sv
// Shares reg_file ports between two requesters through one issue stage and per-requester response slots.
module rf_port_arbiter
    import rf_pkg::*;
(
    input  logic                           clk,
    input  logic                           rst_n,
    input  logic [1:0]                     req_valid,
    output logic [1:0]                     req_ready,
    input  logic [1:0]                     req_write,
    input  logic [1:0][RS_AW-1:0]          req_rs_addr,
    input  logic [1:0][RT_AW-1:0]          req_rt_addr,
    input  logic [1:0][RD_AW-1:0]          req_rd_addr,
    input  logic [1:0][REG_WIDTH-1:0]      req_wdata,
    output logic [1:0]                     rsp_valid,
    input  logic [1:0]                     rsp_ready,
    output logic [1:0][REG_WIDTH-1:0]      rsp_rs_data,
    output logic [1:0][REG_WIDTH-1:0]      rsp_rt_data,
    output logic [1:0]                     rsp_err,
    output logic                           rf_write,
    output logic [RS_AW-1:0]               rf_rs_addr,
    output logic [RT_AW-1:0]               rf_rt_addr,
    output logic [RD_AW-1:0]               rf_rd_addr,
    output logic [REG_WIDTH-1:0]           rf_rd_in,
    input  logic [REG_WIDTH-1:0]           rf_rs_out,
    input  logic [REG_WIDTH-1:0]           rf_rt_out
);

    logic       s1_valid;
    logic       s1_id;
    rf_req_t    s1_req;
    logic [1:0] eligible;
    logic [1:0] gnt;
    logic       gnt_id;
    rf_req_t    granted;
    logic       s1_read;
    logic       rs_err;
    rf_rsp_t    slot [2];
    logic [1:0] slot_valid;

    // A read may only enter when its slot is guaranteed free by the time the data arrives.
    always_comb begin
        eligible = 2'b00;
        for (int i = 0; i < 2; i++) begin
            eligible[i] = req_write[i]
                        | (~(s1_valid & ~s1_req.write & (s1_id == 1'(i)))
                           & (~slot_valid[i] | rsp_ready[i]));
        end
    end

    rr_arb2 u_arb (
        .clk    (clk),
        .rst_n  (rst_n),
        .req    (req_valid & eligible),
        .update (gnt != 2'b00),
        .gnt    (gnt)
    );

    assign req_ready = gnt;
    assign gnt_id    = gnt[1];

    always_comb begin
        granted       = '0;
        granted.write = req_write[gnt_id];
        granted.rs    = req_rs_addr[gnt_id];
        granted.rt    = req_rt_addr[gnt_id];
        granted.rd    = req_rd_addr[gnt_id];
        granted.wdata = req_wdata[gnt_id];
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_valid <= 1'b0;
            s1_id    <= 1'b0;
            s1_req   <= '0;
        end else begin
            s1_valid <= (gnt != 2'b00);
            if (gnt != 2'b00) begin
                s1_id  <= gnt_id;
                s1_req <= granted;
            end
        end
    end

    assign rf_write   = s1_valid & s1_req.write;
    assign rf_rs_addr = s1_req.rs;
    assign rf_rt_addr = s1_req.rt;
    assign rf_rd_addr = s1_req.rd;
    assign rf_rd_in   = s1_req.wdata;

    assign s1_read = s1_valid & ~s1_req.write;
    assign rs_err  = rs_out_of_range(s1_req.rs);

    // A refill takes priority over a clear so a same-edge drain and refill stays valid.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            slot_valid <= 2'b00;
            slot[0]    <= '0;
            slot[1]    <= '0;
        end else begin
            for (int i = 0; i < 2; i++) begin
                if (s1_read && (s1_id == 1'(i))) begin
                    slot_valid[i]      <= 1'b1;
                    slot[i].rs_data    <= rs_err ? '0 : rf_rs_out;
                    slot[i].rt_data    <= rf_rt_out;
                    slot[i].err        <= rs_err;
                end else if (slot_valid[i] && rsp_ready[i]) begin
                    slot_valid[i] <= 1'b0;
                end
            end
        end
    end

    always_comb begin
        rsp_valid   = slot_valid;
        rsp_rs_data = '0;
        rsp_rt_data = '0;
        rsp_err     = '0;
        for (int i = 0; i < 2; i++) begin
            rsp_rs_data[i] = slot[i].rs_data;
            rsp_rt_data[i] = slot[i].rt_data;
            rsp_err[i]     = slot[i].err;
        end
    end

endmodule

// File: tb/tb_rf_port_arbiter.sv
// Directed scoreboard bench for rf_port_arbiter with a behavioural reg_file attached.
module tb_rf_port_arbiter;
    import rf_pkg::*;

    logic                      clk = 1'b0;
    logic                      rst_n = 1'b0;
    logic [1:0]                req_valid;
    logic [1:0]                req_ready;
    logic [1:0]                req_write;
    logic [1:0][RS_AW-1:0]     req_rs_addr;
    logic [1:0][RT_AW-1:0]     req_rt_addr;
    logic [1:0][RD_AW-1:0]     req_rd_addr;
    logic [1:0][REG_WIDTH-1:0] req_wdata;
    logic [1:0]                rsp_valid;
    logic [1:0]                rsp_ready;
    logic [1:0][REG_WIDTH-1:0] rsp_rs_data;
    logic [1:0][REG_WIDTH-1:0] rsp_rt_data;
    logic [1:0]                rsp_err;
    logic                      rf_write;
    logic [RS_AW-1:0]          rf_rs_addr;
    logic [RT_AW-1:0]          rf_rt_addr;
    logic [RD_AW-1:0]          rf_rd_addr;
    logic [REG_WIDTH-1:0]      rf_rd_in;
    logic [REG_WIDTH-1:0]      rf_rs_out;
    logic [REG_WIDTH-1:0]      rf_rt_out;

    logic [7:0] rf_mem  [16] = '{8'h10, 8'h11, 8'h12, 8'h13, 8'h14, 8'h15, 8'h16, 8'h17,
                                 8'h18, 8'h19, 8'h1A, 8'h1B, 8'h1C, 8'h1D, 8'h1E, 8'h1F};
    logic [7:0] exp_mem [16] = '{8'h10, 8'h11, 8'h12, 8'h13, 8'h14, 8'h15, 8'h16, 8'h17,
                                 8'h18, 8'h19, 8'h1A, 8'h1B, 8'h1C, 8'h1D, 8'h1E, 8'h1F};

    rf_rsp_t exp_q0 [$];
    rf_rsp_t exp_q1 [$];

    int total  = 0;
    int passed = 0;
    int failed = 0;

    always #5 clk = ~clk;

    rf_port_arbiter dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .req_valid   (req_valid),
        .req_ready   (req_ready),
        .req_write   (req_write),
        .req_rs_addr (req_rs_addr),
        .req_rt_addr (req_rt_addr),
        .req_rd_addr (req_rd_addr),
        .req_wdata   (req_wdata),
        .rsp_valid   (rsp_valid),
        .rsp_ready   (rsp_ready),
        .rsp_rs_data (rsp_rs_data),
        .rsp_rt_data (rsp_rt_data),
        .rsp_err     (rsp_err),
        .rf_write    (rf_write),
        .rf_rs_addr  (rf_rs_addr),
        .rf_rt_addr  (rf_rt_addr),
        .rf_rd_addr  (rf_rd_addr),
        .rf_rd_in    (rf_rd_in),
        .rf_rs_out   (rf_rs_out),
        .rf_rt_out   (rf_rt_out)
    );

    // Behavioural reg_file: combinational reads, write on the rising edge.
    assign rf_rs_out = rf_mem[rf_rs_addr];
    assign rf_rt_out = rf_mem[rf_rt_addr];
    always @(posedge clk) begin
        if (rf_write) rf_mem[rf_rd_addr] <= rf_rd_in;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else begin
            failed++;
            $error("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic set_req(input int i, input logic wr, input logic [3:0] rs, input logic [2:0] rt,
                           input logic [1:0] rd, input logic [7:0] wd);
        req_valid[i]   = 1'b1;
        req_write[i]   = wr;
        req_rs_addr[i] = rs;
        req_rt_addr[i] = rt;
        req_rd_addr[i] = rd;
        req_wdata[i]   = wd;
    endtask

    task automatic clear_req(input int i);
        req_valid[i] = 1'b0;
    endtask

    task automatic push_exp(input int i, input logic [3:0] rs, input logic [2:0] rt);
        rf_rsp_t e;
        e.err     = (rs >= 4'd12);
        e.rs_data = e.err ? 8'h00 : exp_mem[rs];
        e.rt_data = exp_mem[rt];
        if (i == 0) exp_q0.push_back(e);
        else        exp_q1.push_back(e);
    endtask

    task automatic check_rsp(input int i, input string tag);
        rf_rsp_t e;
        if ((i == 0 && exp_q0.size() == 0) || (i == 1 && exp_q1.size() == 0)) begin
            total++;
            failed++;
            $error("[TB] FAIL %s_queue: observed empty scoreboard expected an entry", tag);
        end else begin
            e = (i == 0) ? exp_q0.pop_front() : exp_q1.pop_front();
            check({tag, "_valid"}, rsp_valid[i], 1);
            check({tag, "_rs"}, rsp_rs_data[i], e.rs_data);
            check({tag, "_rt"}, rsp_rt_data[i], e.rt_data);
            check({tag, "_err"}, rsp_err[i], e.err);
        end
    endtask

    // Waits a bounded number of cycles for a response, checks it, then consumes it.
    task automatic wait_rsp(input int i, input string tag);
        for (int k = 0; k < 8; k++) begin
            @(negedge clk);
            if (rsp_valid[i]) break;
        end
        check_rsp(i, tag);
        rsp_ready[i] = 1'b1;
        next_cycle();
        rsp_ready[i] = 1'b0;
    endtask

    initial begin
        logic [1:0] exp_gnt [4];
        exp_gnt = '{2'b01, 2'b10, 2'b01, 2'b10};
        req_valid   = '0;
        req_write   = '0;
        req_rs_addr = '0;
        req_rt_addr = '0;
        req_rd_addr = '0;
        req_wdata   = '0;
        rsp_ready   = '0;

        #3;
        check("rst_req_ready", req_ready, 0);
        check("rst_rf_write", rf_write, 0);
        check("rst_rf_rs_addr", rf_rs_addr, 0);
        check("rst_rf_rt_addr", rf_rt_addr, 0);
        check("rst_rf_rd_addr", rf_rd_addr, 0);
        check("rst_rf_rd_in", rf_rd_in, 0);
        check("rst_rsp_valid", rsp_valid, 0);
        check("rst_rsp_rs_data", rsp_rs_data, 0);
        check("rst_rsp_rt_data", rsp_rt_data, 0);
        check("rst_rsp_err", rsp_err, 0);
        next_cycle();
        next_cycle();
        rst_n = 1'b1;

        // Contention between two writers straight out of reset.
        set_req(0, 1'b1, 4'd0, 3'd0, 2'd2, 8'hAA);
        set_req(1, 1'b1, 4'd0, 3'd0, 2'd3, 8'h55);
        exp_mem[2] = 8'hAA;
        exp_mem[3] = 8'h55;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            check("cont_gnt", req_ready, exp_gnt[k]);
            if (k > 0) begin
                check("cont_rf_write", rf_write, 1);
                check("cont_rf_rd_addr", rf_rd_addr, (k % 2 == 1) ? 2 : 3);
            end
            next_cycle();
        end
        clear_req(0);
        clear_req(1);
        @(negedge clk);
        check("cont_last_rd_addr", rf_rd_addr, 3);
        check("cont_last_rd_in", rf_rd_in, 8'h55);
        next_cycle();
        check("cont_idle_rf_write", rf_write, 0);
        check("cont_mem2", rf_mem[2], exp_mem[2]);
        check("cont_mem3", rf_mem[3], exp_mem[3]);

        // Write followed by a read of the same register one cycle later.
        set_req(0, 1'b1, 4'd0, 3'd0, 2'd1, 8'h7F);
        exp_mem[1] = 8'h7F;
        @(negedge clk);
        check("wr_gnt", req_ready, 2'b01);
        next_cycle();
        set_req(0, 1'b0, 4'd1, 3'd1, 2'd0, 8'h00);
        push_exp(0, 4'd1, 3'd1);
        @(negedge clk);
        check("rd_gnt", req_ready, 2'b01);
        check("wr_rf_write", rf_write, 1);
        check("wr_rf_rd_in", rf_rd_in, 8'h7F);
        next_cycle();
        clear_req(0);
        @(negedge clk);
        check("wr_one_cycle", rf_write, 0);
        check("rd_not_yet", rsp_valid[0], 0);
        next_cycle();
        @(negedge clk);
        check_rsp(0, "wr_rd");
        rsp_ready[0] = 1'b1;
        next_cycle();
        rsp_ready[0] = 1'b0;
        @(negedge clk);
        check("wr_rd_cleared", rsp_valid[0], 0);

        // Backpressure on requester 1 while requester 0 keeps writing.
        next_cycle();
        set_req(1, 1'b0, 4'd8, 3'd4, 2'd0, 8'h00);
        push_exp(1, 4'd8, 3'd4);
        @(negedge clk);
        check("bp_first_gnt", req_ready, 2'b10);
        next_cycle();
        set_req(1, 1'b0, 4'd2, 3'd3, 2'd0, 8'h00);
        push_exp(1, 4'd2, 3'd3);
        set_req(0, 1'b1, 4'd0, 3'd0, 2'd0, 8'h33);
        exp_mem[0] = 8'h33;
        @(negedge clk);
        check("bp_blocked_s1", req_ready, 2'b01);
        next_cycle();
        set_req(0, 1'b1, 4'd0, 3'd0, 2'd1, 8'h44);
        exp_mem[1] = 8'h44;
        @(negedge clk);
        check("bp_blocked_slot", req_ready, 2'b01);
        check("bp_wr_flow", rf_write, 1);
        check("bp_slot_held", rsp_valid[1], 1);
        next_cycle();
        set_req(0, 1'b1, 4'd0, 3'd0, 2'd0, 8'h66);
        exp_mem[0] = 8'h66;
        @(negedge clk);
        check("bp_still_blocked", req_ready, 2'b01);
        next_cycle();
        clear_req(0);
        rsp_ready[1] = 1'b1;
        @(negedge clk);
        check("bp_release", req_ready, 2'b10);
        check_rsp(1, "bp_first");
        next_cycle();
        clear_req(1);
        rsp_ready[1] = 1'b0;
        wait_rsp(1, "bp_second");
        check("bp_mem0", rf_mem[0], exp_mem[0]);
        check("bp_mem1", rf_mem[1], exp_mem[1]);

        // Out-of-range rs address and the last legal one.
        set_req(0, 1'b0, 4'd12, 3'd5, 2'd0, 8'h00);
        push_exp(0, 4'd12, 3'd5);
        @(negedge clk);
        check("oor_gnt", req_ready, 2'b01);
        next_cycle();
        clear_req(0);
        wait_rsp(0, "oor12");
        set_req(0, 1'b0, 4'd11, 3'd5, 2'd0, 8'h00);
        push_exp(0, 4'd11, 3'd5);
        @(negedge clk);
        check("rs11_gnt", req_ready, 2'b01);
        next_cycle();
        clear_req(0);
        wait_rsp(0, "rs11");

        // Slot drained in the same cycle the next read for it is accepted.
        rsp_ready[1] = 1'b1;
        set_req(1, 1'b0, 4'd3, 3'd6, 2'd0, 8'h00);
        push_exp(1, 4'd3, 3'd6);
        @(negedge clk);
        check("dr_first_gnt", req_ready, 2'b10);
        next_cycle();
        set_req(1, 1'b0, 4'd9, 3'd7, 2'd0, 8'h00);
        push_exp(1, 4'd9, 3'd7);
        @(negedge clk);
        check("dr_s1_block", req_ready, 2'b00);
        next_cycle();
        @(negedge clk);
        check("dr_refill_gnt", req_ready, 2'b10);
        check_rsp(1, "dr_first");
        next_cycle();
        clear_req(1);
        wait_rsp(1, "dr_second");
        rsp_ready[1] = 1'b0;

        // Reset while a write sits in the issue stage and slot 1 is full.
        set_req(1, 1'b0, 4'd4, 3'd4, 2'd0, 8'h00);
        @(negedge clk);
        check("rr_rd_gnt", req_ready, 2'b10);
        next_cycle();
        clear_req(1);
        next_cycle();
        set_req(0, 1'b1, 4'd0, 3'd0, 2'd0, 8'hFF);
        @(negedge clk);
        check("rr_wr_gnt", req_ready, 2'b01);
        next_cycle();
        clear_req(0);
        #1;
        check("rr_pre_write", rf_write, 1);
        check("rr_pre_slot", rsp_valid[1], 1);
        rst_n = 1'b0;
        #1;
        check("rr_async_write", rf_write, 0);
        next_cycle();
        check("rr_mem0_kept", rf_mem[0], exp_mem[0]);
        check("rr_rsp_valid", rsp_valid, 0);
        check("rr_rsp_rs_data", rsp_rs_data, 0);
        check("rr_rsp_rt_data", rsp_rt_data, 0);
        check("rr_rsp_err", rsp_err, 0);
        check("rr_rf_rs_addr", rf_rs_addr, 0);
        check("rr_rf_rd_addr", rf_rd_addr, 0);
        check("rr_rf_rd_in", rf_rd_in, 0);
        check("rr_req_ready", req_ready, 0);
        rst_n = 1'b1;
        next_cycle();

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
